// File: rtl/pc_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : mips_defs (package)                                          |
// | Description : next-PC select codes, default vectors and sequencer states   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package mips_defs;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_BR  = 3'b001;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;
    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_EXC = 3'b101;

    localparam logic [31:0] DEF_START_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_irq_sync.sv
// +----------------------------------------------------------------------------+
// | Module      : irq_sync                                                     |
// | Description : multi-flop synchronizer for irq_in with rising-edge pulse    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module irq_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic irq_rise
);

    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], irq_in};
            r_prev <= r_sync[SYNC_STG-1];
        end
    end

    // One pulse per low-to-high transition; a held level never re-fires.
    assign irq_rise = r_sync[SYNC_STG-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : pc_sequencer                                                 |
// | Description : fetch/next-PC sequencer with IRQ pending and kernel masking  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module pc_sequencer
    import mips_defs::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] START_VEC = ADDR_W'(DEF_START_VEC),
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(DEF_IRQ_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int                SYNC_STG  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              irq_in,
    input  logic [2:0]        pcsrc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] imm_ext,
    input  logic [25:0]       jt,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              cpu_continue,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              irq_req
);

    localparam int              MSB    = ADDR_W - 1;
    localparam logic [MSB-1:0]  c_four = (ADDR_W-1)'(4);

    seq_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_instr;
    logic              r_pending;

    logic              w_load_instr;
    logic              w_retire;
    logic              w_irq_rise;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [MSB-1:0]    w_br_off;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_unused_imm;

    irq_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_irq_sync (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .irq_rise (w_irq_rise)
    );

    // Address arithmetic wraps inside the low ADDR_W-1 bits; the kernel bit is never carried into.
    assign w_pc_plus4   = {r_pc[MSB], r_pc[MSB-1:0] + c_four};
    assign w_br_off     = {imm_ext[ADDR_W-4:0], 2'b00};
    assign w_unused_imm = ^imm_ext[MSB -: 2];

    always_comb begin
        w_jump_tgt       = r_pc;
        w_jump_tgt[27:0] = {jt, 2'b00};
    end

    always_comb begin
        w_next_pc = START_VEC;
        case (pcsrc)
            PCSRC_SEQ: w_next_pc = w_pc_plus4;
            PCSRC_BR:  w_next_pc = branch_taken
                                 ? {w_pc_plus4[MSB], w_pc_plus4[MSB-1:0] + w_br_off}
                                 : w_pc_plus4;
            PCSRC_J:   w_next_pc = w_jump_tgt;
            // jr can keep or drop kernel mode but never raise it from user mode.
            PCSRC_JR:  w_next_pc = {r_pc[MSB] & rs_data[MSB], rs_data[MSB-1:0]};
            PCSRC_IRQ: w_next_pc = IRQ_VEC;
            PCSRC_EXC: w_next_pc = EXC_VEC;
            default:   w_next_pc = START_VEC;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        w_load_instr = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_load_instr = 1'b1;
                    w_state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (cpu_continue) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= START_VEC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_instr) r_instr <= imem_rdata;
            if (w_retire)     r_pc    <= w_next_pc;
        end
    end

    // A new edge in the same cycle as the IRQ retire keeps the request pending.
    always_ff @(posedge clk) begin
        if (reset)
            r_pending <= 1'b0;
        else if (w_irq_rise)
            r_pending <= 1'b1;
        else if (w_retire && pcsrc == PCSRC_IRQ)
            r_pending <= 1'b0;
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign instr     = r_instr;
    assign irq_req   = r_pending & ~r_pc[MSB];

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_sequencer                                              |
// | Description : directed self-checking bench for pc_sequencer                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq_in;
    logic [2:0]  pcsrc;
    logic        branch_taken;
    logic [31:0] imm_ext;
    logic [25:0] jt;
    logic [31:0] rs_data;
    logic        cpu_continue;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        irq_req;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .pcsrc        (pcsrc),
        .branch_taken (branch_taken),
        .imm_ext      (imm_ext),
        .jt           (jt),
        .rs_data      (rs_data),
        .cpu_continue (cpu_continue),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .irq_req      (irq_req)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the DUT in FETCH at addr; acks in the same cycle.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_req"},  {31'b0, imem_req}, 32'd1);
        chk({tag, "_addr"}, imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        chk({tag, "_vld"},   {31'b0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, data);
    endtask

    task automatic retire(input string tag, input logic [2:0] src, input logic [31:0] exp_pc);
        pcsrc        = src;
        cpu_continue = 1'b1;
        tick();
        cpu_continue = 1'b0;
        pcsrc        = 3'b000;
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    task automatic step(input string tag, input logic [2:0] src, input logic [31:0] exp_pc);
        retire(tag, src, exp_pc);
        fetch(tag, exp_pc, exp_pc ^ 32'hA5A5_0000);
    endtask

    initial begin
        reset = 1'b1; irq_in = 1'b0; pcsrc = 3'b000; branch_taken = 1'b0;
        imm_ext = '0; jt = '0; rs_data = '0; cpu_continue = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        tick(); tick();
        chk("rst_pc",    pc, 32'h0);
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_vld",   {31'b0, instr_valid}, 32'd0);
        chk("rst_irq",   {31'b0, irq_req}, 32'd0);

        // reset release: IDLE, then FETCH, then EXEC two edges later
        reset = 1'b0;
        tick();
        fetch("t1", 32'h0, 32'h2008_0005);
        chk("t1_pc4", pc_plus4, 32'h4);

        // branches
        jt = 26'h4;
        step("t2_j", 3'b010, 32'h0000_0010);
        branch_taken = 1'b1; imm_ext = 32'hFFFF_FFFE;
        step("t2_bt", 3'b001, 32'h0000_000C);
        step("t2_j2", 3'b010, 32'h0000_0010);
        branch_taken = 1'b0;
        step("t2_bn", 3'b001, 32'h0000_0014);

        // kernel bit handling
        rs_data = 32'h8000_0100;
        step("t3_jru", 3'b011, 32'h0000_0100);
        step("t3_exc", 3'b101, 32'h8000_0008);
        step("t3_jrk", 3'b011, 32'h8000_0100);
        chk("t3_pc4k", pc_plus4, 32'h8000_0104);
        step("t3_seqk", 3'b000, 32'h8000_0104);
        rs_data = 32'hFFFF_FFFC;
        step("t3_jrtop", 3'b011, 32'hFFFF_FFFC);
        step("t3_wrapk", 3'b000, 32'h8000_0000);
        rs_data = 32'h7FFF_FFFC;
        step("t3_jrdrop", 3'b011, 32'h7FFF_FFFC);
        step("t3_wrapu", 3'b000, 32'h0000_0000);
        jt = 26'h10;
        step("t3_j40", 3'b010, 32'h0000_0040);
        rs_data = 32'h8000_0000;
        step("t3_jrblk", 3'b011, 32'h0000_0000);
        step("t3_rst", 3'b110, 32'h0000_0000);

        // IRQ: synchronizer latency, masking in kernel, single event per level
        jt = 26'h8;
        step("t4_j20", 3'b010, 32'h0000_0020);
        irq_in = 1'b1;
        tick(); tick();
        chk("t4_irq_early", {31'b0, irq_req}, 32'd0);
        tick();
        chk("t4_irq_set", {31'b0, irq_req}, 32'd1);
        retire("t4_vec", 3'b100, 32'h8000_0004);
        chk("t4_irq_clr", {31'b0, irq_req}, 32'd0);
        fetch("t4_vec", 32'h8000_0004, 32'h4200_0018);
        irq_in = 1'b0;
        tick(); tick(); tick();
        irq_in = 1'b1;
        repeat (5) tick();
        chk("t4_irq_masked", {31'b0, irq_req}, 32'd0);
        rs_data = 32'h0000_0080;
        retire("t4_jru", 3'b011, 32'h0000_0080);
        chk("t4_irq_unmask", {31'b0, irq_req}, 32'd1);
        fetch("t4_jru", 32'h0000_0080, 32'h0000_0008);
        step("t4_vec2", 3'b100, 32'h8000_0004);
        chk("t4_irq_clr2", {31'b0, irq_req}, 32'd0);
        rs_data = 32'h0000_0100;
        step("t4_ret", 3'b011, 32'h0000_0100);
        repeat (4) tick();
        chk("t4_irq_level", {31'b0, irq_req}, 32'd0);
        irq_in = 1'b0;

        // stall in EXEC
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_pc",    pc, 32'h0000_0100);
            chk("t5_instr", instr, 32'h0000_0100 ^ 32'hA5A5_0000);
            chk("t5_req",   {31'b0, imem_req}, 32'd0);
        end
        retire("t5_rel", 3'b000, 32'h0000_0104);
        chk("t5_req1", {31'b0, imem_req}, 32'd1);
        tick();
        chk("t5_req2",  {31'b0, imem_req}, 32'd1);
        chk("t5_addr2", imem_addr, 32'h0000_0104);
        fetch("t5_f", 32'h0000_0104, 32'h1234_5678);

        // reset in FETCH, late ack ignored
        retire("t6_seq", 3'b000, 32'h0000_0108);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_pc",    pc, 32'h0);
        chk("t6_instr", instr, 32'h0);
        chk("t6_req",   {31'b0, imem_req}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("t6_instr2", instr, 32'h0);
        chk("t6_vld2",   {31'b0, instr_valid}, 32'd0);
        chk("t6_req2",   {31'b0, imem_req}, 32'd1);
        fetch("t6_f", 32'h0, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
